// File: rtl/multicycle_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multicycle_controller_if                                           |
// | Shared instruction/data memory port: request/ready handshake.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface multicycle_controller_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_wen;
  logic [XLEN-1:0] mem_addr;
  logic [2:0]      mem_func3;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  modport master (
    output mem_req, mem_wen, mem_addr, mem_func3,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_wen, mem_addr, mem_func3,
    output mem_rdata, mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multicycle_controller                                              |
// | FETCH/EXECUTE/MEMORY/TRAP sequencer owning PC, IR and instret.     |
// | Option: MULTICYCLE_CTRL_MISALIGN_TRAP_EN enables alignment traps.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module multicycle_controller #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              CNT_W    = 32
) (
  input  wire logic                clk,
  input  wire logic                rst,
  multicycle_controller_if.master  mem,
  input  wire logic [1:0]          action_type,
  input  wire logic [2:0]          func3,
  input  wire logic [XLEN-1:0]     immediate,
  input  wire logic [XLEN-1:0]     rs1_data,
  input  wire logic [XLEN-1:0]     pc_next,
  output logic                     reg_wen,
  output logic [XLEN-1:0]          pc,
  output logic [XLEN-1:0]          instruction,
  output logic [CNT_W-1:0]         instret,
  output logic                     trap
);

  localparam logic [1:0] ACT_STORE  = 2'd0;
  localparam logic [1:0] ACT_LOAD   = 2'd1;
  localparam logic [1:0] ACT_BRANCH = 2'd2;
  localparam logic [1:0] ACT_JAL    = 2'd3;
  localparam logic [2:0] FUNC3_WORD = 3'b010;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXECUTE = 2'd1,
    S_MEMORY  = 2'd2,
    S_TRAP    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instruction_q, instruction_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic              req_c;
  logic              wen_c;
  logic [XLEN-1:0]   addr_c;
  logic [2:0]        func3_c;
  logic              reg_wen_c;

  logic [XLEN-1:0]   eff_addr;
  logic              is_mem_op;
  logic              bad_data_addr;
  logic              bad_pc_next;

  assign eff_addr  = rs1_data + immediate;
  assign is_mem_op = (action_type == ACT_STORE) || (action_type == ACT_LOAD);

`ifdef MULTICYCLE_CTRL_MISALIGN_TRAP_EN
  assign bad_data_addr = ((func3[1:0] == 2'b01) && eff_addr[0]) ||
                         ((func3[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00));
  assign bad_pc_next   = (pc_next[1:0] != 2'b00);
`else
  assign bad_data_addr = 1'b0;
  assign bad_pc_next   = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instruction_d = instruction_q;
    instret_d     = instret_q;
    req_c         = 1'b0;
    wen_c         = 1'b0;
    addr_c        = pc_q;
    func3_c       = FUNC3_WORD;
    reg_wen_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem.mem_ready) begin
          instruction_d = mem.mem_rdata;
          state_d       = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_mem_op) begin
          state_d = bad_data_addr ? S_TRAP : S_MEMORY;
        end else if (bad_pc_next) begin
          state_d = S_TRAP;
        end else begin
          pc_d      = pc_next;
          instret_d = instret_q + CNT_ONE;
          reg_wen_c = (action_type == ACT_JAL);
          state_d   = S_FETCH;
        end
      end
      S_MEMORY: begin
        // Address and size derive from the held instruction, so they stay
        // constant for the whole wait period without extra registers.
        req_c   = 1'b1;
        wen_c   = (action_type == ACT_STORE);
        addr_c  = eff_addr;
        func3_c = func3;
        if (mem.mem_ready) begin
          pc_d      = pc_next;
          instret_d = instret_q + CNT_ONE;
          reg_wen_c = (action_type == ACT_LOAD);
          state_d   = S_FETCH;
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instruction_q <= {XLEN{1'b0}};
      instret_q     <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instruction_q <= instruction_d;
      instret_q     <= instret_d;
    end
  end

  // Strobes are masked during reset so an abandoned request drops at once.
  assign mem.mem_req   = req_c & ~rst;
  assign mem.mem_wen   = wen_c & ~rst;
  assign mem.mem_addr  = addr_c;
  assign mem.mem_func3 = func3_c;
  assign reg_wen       = reg_wen_c & ~rst;

  assign pc          = pc_q;
  assign instruction = instruction_q;
  assign instret     = instret_q;

`ifdef MULTICYCLE_CTRL_MISALIGN_TRAP_EN
  assign trap = (state_q == S_TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// Testbench for multicycle_controller: queue-based scoreboard of memory
// handshakes and register write pulses, plus directed timing checks.
module tb_multicycle_controller;
  localparam logic [1:0] A_STORE  = 2'd0;
  localparam logic [1:0] A_LOAD   = 2'd1;
  localparam logic [1:0] A_BRANCH = 2'd2;
  localparam logic [1:0] A_JAL    = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  action_type = A_JAL;
  logic [2:0]  func3 = 3'b010;
  logic [31:0] immediate = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] pc_next = '0;
  logic        reg_wen;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] instret;
  logic        trap;

  int checks = 0;
  int failures = 0;

  multicycle_controller_if #(.XLEN(32)) mif ();

  multicycle_controller #(.XLEN(32), .RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem(mif.master),
    .action_type(action_type), .func3(func3), .immediate(immediate),
    .rs1_data(rs1_data), .pc_next(pc_next), .reg_wen(reg_wen), .pc(pc),
    .instruction(instruction), .instret(instret), .trap(trap)
  );

  always #5 clk = ~clk;

  // Memory responder: a table of (wait states, read data) consumed per handshake.
  int          resp_waits [0:63];
  logic [31:0] resp_data  [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          wcnt = 0;

  assign mif.mem_ready = mif.mem_req && (rd_ptr != wr_ptr) && (wcnt >= resp_waits[rd_ptr[5:0]]);
  assign mif.mem_rdata = resp_data[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (rst) begin
      wcnt   <= 0;
      rd_ptr <= wr_ptr;
    end else if (mif.mem_req && mif.mem_ready) begin
      wcnt   <= 0;
      rd_ptr <= rd_ptr + 1;
    end else if (mif.mem_req) begin
      wcnt   <= wcnt + 1;
    end else begin
      wcnt   <= 0;
    end
  end

  task automatic push_resp(input int waits, input logic [31:0] data);
    resp_waits[wr_ptr[5:0]] = waits;
    resp_data[wr_ptr[5:0]]  = data;
    wr_ptr = wr_ptr + 1;
  endtask

  typedef struct packed {
    logic        is_reg;
    logic        wen;
    logic [31:0] addr;
    logic [2:0]  f3;
  } ev_t;

  ev_t exp_q[$];

  task automatic push_mem(input logic wen, input logic [31:0] addr, input logic [2:0] f3);
    ev_t e;
    e.is_reg = 1'b0; e.wen = wen; e.addr = addr; e.f3 = f3;
    exp_q.push_back(e);
  endtask

  task automatic push_reg();
    ev_t e;
    e.is_reg = 1'b1; e.wen = 1'b0; e.addr = '0; e.f3 = '0;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected event per observed handshake or reg_wen pulse.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (mif.mem_req && mif.mem_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_mem_unexpected actual=%0h required=none", mif.mem_addr);
        end else begin
          e = exp_q.pop_front();
          if (e.is_reg || e.wen !== mif.mem_wen || e.addr !== mif.mem_addr || e.f3 !== mif.mem_func3) begin
            failures++;
            $display("FAIL sb_mem actual=wen%0b/%08h/f%0d required=reg%0b wen%0b/%08h/f%0d",
                     mif.mem_wen, mif.mem_addr, mif.mem_func3, e.is_reg, e.wen, e.addr, e.f3);
          end
        end
      end
      if (reg_wen) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_reg_unexpected actual=reg_wen required=none");
        end else begin
          e = exp_q.pop_front();
          if (!e.is_reg) begin
            failures++;
            $display("FAIL sb_reg actual=reg_wen required=mem %08h", e.addr);
          end
        end
      end
    end
  end

  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_instret = 32'h0;
  logic [31:0] exp_instr = 32'h0;

  task automatic drive(input logic [1:0] act, input logic [2:0] f3, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] pcn);
    action_type = act; func3 = f3; immediate = imm; rs1_data = rs1; pc_next = pcn;
  endtask

  task automatic run_instr(input string name, input logic [1:0] act, input logic [2:0] f3,
                           input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] pcn,
                           input logic [31:0] word, input int fw, input int mw);
    int cyc;
    int lat;
    bit hold_ok;
    bit is_mem;
    logic [31:0] ea;
    is_mem = (act == A_STORE) || (act == A_LOAD);
    ea = rs1 + imm;
    push_resp(fw, word);
    push_mem(1'b0, exp_pc, 3'b010);
    if (act == A_JAL) push_reg();
    if (is_mem) begin
      push_resp(mw, 32'hA5A5_0000);
      push_mem(act == A_STORE, ea, f3);
      if (act == A_LOAD) push_reg();
    end
    drive(act, f3, imm, rs1, pcn);
    lat = (fw + 1) + 1 + (is_mem ? (mw + 1) : 0);
    cyc = 0;
    hold_ok = 1'b1;
    while (1) begin
      if (cyc <= fw) begin
        if (!(mif.mem_req && !mif.mem_wen && mif.mem_addr == exp_pc &&
              mif.mem_func3 == 3'b010 && instruction == exp_instr)) hold_ok = 1'b0;
      end else if (is_mem && cyc >= fw + 2) begin
        if (!(mif.mem_req && mif.mem_wen == (act == A_STORE) &&
              mif.mem_addr == ea && mif.mem_func3 == f3)) hold_ok = 1'b0;
      end else if (mif.mem_req) begin
        hold_ok = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (instret != exp_instret || cyc > 200) break;
    end
    exp_pc = pcn;
    exp_instret = exp_instret + 1;
    exp_instr = word;
    chk({name, "_latency"}, 64'(cyc), 64'(lat));
    chk({name, "_hold"}, 64'(hold_ok), 64'd1);
    chk({name, "_pc"}, 64'(pc), 64'(exp_pc));
    chk({name, "_instret"}, 64'(instret), 64'(exp_instret));
    chk({name, "_instr"}, 64'(instruction), 64'(exp_instr));
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 64'(mif.mem_req), 64'd0);
    chk("rst_reg_wen", 64'(reg_wen), 64'd0);
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_instret", 64'(instret), 64'h0);
    chk("rst_instr", 64'(instruction), 64'h0);
    chk("rst_trap", 64'(trap), 64'd0);
    rst = 1'b0;
    #1;
    chk("first_req", 64'(mif.mem_req), 64'd1);
    chk("first_addr", 64'(mif.mem_addr), 64'h0);

    run_instr("jal0",    A_JAL,    3'b000, 32'h5,  32'h0,        32'h4,  32'h0050_0093, 0, 0);
    run_instr("br_wait", A_BRANCH, 3'b000, 32'h4,  32'h0,        32'h8,  32'h0000_0463, 3, 0);
    run_instr("load_w",  A_LOAD,   3'b010, 32'h8,  32'h100,      32'hC,  32'h0081_2083, 0, 2);
    run_instr("store_w", A_STORE,  3'b010, 32'h8,  32'hFFFF_FFFC, 32'h10, 32'h0011_2423, 1, 1);
    run_instr("load_h",  A_LOAD,   3'b001, 32'h6,  32'h200,      32'h14, 32'h0061_1083, 0, 0);
    run_instr("jal_far", A_JAL,    3'b000, 32'h2C, 32'h0,        32'h40, 32'h02C0_00EF, 0, 0);

    // Reset while a LOAD waits in MEMORY.
    push_resp(0, 32'h0081_2083);
    push_resp(20, 32'h0);
    push_mem(1'b0, exp_pc, 3'b010);
    drive(A_LOAD, 3'b010, 32'h8, 32'h300, 32'h44);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_mem_req", 64'(mif.mem_req), 64'd1);
    chk("mid_mem_addr", 64'(mif.mem_addr), 64'h308);
    rst = 1'b1;
    #1;
    chk("rst_drop_req", 64'(mif.mem_req), 64'd0);
    @(posedge clk); #1;
    exp_q.delete();
    exp_pc = 32'h0; exp_instret = 32'h0; exp_instr = 32'h0;
    chk("rst2_pc", 64'(pc), 64'h0);
    chk("rst2_instret", 64'(instret), 64'h0);
    chk("rst2_instr", 64'(instruction), 64'h0);
    chk("rst2_mem_req", 64'(mif.mem_req), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst2_first_req", 64'(mif.mem_req), 64'd1);

    run_instr("jal_after_rst", A_JAL, 3'b000, 32'h4, 32'h0, 32'h4, 32'h0040_00EF, 0, 0);

`ifdef MULTICYCLE_CTRL_MISALIGN_TRAP_EN
    push_resp(0, 32'h0021_2083);
    push_mem(1'b0, exp_pc, 3'b010);
    drive(A_LOAD, 3'b010, 32'h2, 32'h100, 32'h8);
    repeat (2) @(posedge clk);
    #1;
    chk("trap_set", 64'(trap), 64'd1);
    chk("trap_mem_req", 64'(mif.mem_req), 64'd0);
    chk("trap_pc", 64'(pc), 64'(exp_pc));
    chk("trap_instret", 64'(instret), 64'(exp_instret));
    repeat (4) @(posedge clk);
    #1;
    chk("trap_sticky", 64'(trap), 64'd1);
    chk("trap_req_idle", 64'(mif.mem_req), 64'd0);
    chk("trap_pc_frozen", 64'(pc), 64'(exp_pc));
`else
    run_instr("load_mis", A_LOAD, 3'b010, 32'h2, 32'h100, 32'h8, 32'h0021_2083, 0, 1);
    chk("no_trap", 64'(trap), 64'd0);
`endif

    @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multi-cycle control sequencer for the RISC-V core, replacing the fixed three-state fetch/execute/memory controller. It owns the PC, instruction register and retired-instruction counter. It drives a single shared instruction/data memory port through a request/ready handshake, so memory may insert any number of wait states. It sits between the unified memory and the decode/ALU/register-file datapath.

## Interface
Parameters:
- XLEN, 32, datapath, address and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- action_type  input  2  decoded class: 0 STORE, 1 LOAD, 2 BRANCH, 3 JAL (JAL also covers ALU/JALR writeback-type instructions).
- func3  input  3  instruction func3; selects access size.
- immediate  input  XLEN  decoded immediate.
- rs1_data  input  XLEN  register-file rs1 read data.
- pc_next  input  XLEN  next-PC value computed by the datapath from the current instruction.
- mem_rdata  input  XLEN  memory read data; valid only when mem_ready=1.
- mem_ready  input  1  memory has completed the current request this cycle.
- mem_req  output  1  memory request valid.
- mem_wen  output  1  write enable, qualified by mem_req.
- mem_addr  output  XLEN  memory byte address.
- mem_func3  output  3  access size; 3'b010 for fetches.
- reg_wen  output  1  register-file write enable (single-cycle pulse).
- pc  output  XLEN  address of the current instruction.
- instruction  output  XLEN  instruction register.
- instret  output  CNT_W  retired-instruction count.
- trap  output  1  sticky fault flag.

## Operation
- States: FETCH, EXECUTE, MEMORY, TRAP.
- FETCH: mem_req=1, mem_wen=0, mem_addr=pc, mem_func3=010.
  - Holds until mem_ready.
  - On mem_ready: instruction <= mem_rdata, go to EXECUTE.
- EXECUTE: mem_req=0. Lasts exactly one cycle.
  - STORE/LOAD: go to MEMORY. pc is not updated yet.
  - BRANCH/JAL: pc <= pc_next, instret += 1, go to FETCH.
  - reg_wen=1 in this cycle only for JAL.
- MEMORY: mem_req=1, mem_addr=rs1_data+immediate (modulo 2^XLEN), mem_func3=func3, mem_wen=(action_type==STORE).
  - Holds until mem_ready.
  - On mem_ready: pc <= pc_next, instret += 1, go to FETCH.
  - For LOAD, reg_wen=1 in the mem_ready cycle only.
- TRAP: all of mem_req, mem_wen and reg_wen are 0. trap=1. pc, instruction and instret are frozen. Exit only via rst.
- reg_wen is never asserted for STORE or BRANCH.
- instret wraps from 2^CNT_W-1 to 0.
- Datapath inputs derive from instruction, which is stable outside FETCH. The controller does not register them.

## Timing
- Reset (rst high at an edge), from any state including mid-handshake:
  - state=FETCH, pc=RESET_PC, instruction=0, instret=0, trap=0.
  - While rst is high, mem_req, mem_wen and reg_wen are forced to 0.
- The first fetch request appears in the first cycle after rst deasserts.
- A request abandoned by reset is dropped. Memory must tolerate a mem_req deassertion without mem_ready.
- While mem_req=1 and mem_ready=0: mem_addr, mem_wen and mem_func3 are held constant.
- mem_ready is ignored when mem_req=0.
- Latency with a memory that asserts mem_ready N cycles after request (N≥0, same-cycle allowed):
  - BRANCH/JAL: (N+1)+1 cycles.
  - LOAD/STORE: (N+1)+1+(N+1) cycles.
- Zero-wait minimums: 2 cycles for BRANCH/JAL, 3 cycles for LOAD/STORE.
- Outputs are combinational from state and inputs. reg_wen may therefore follow mem_ready combinationally.

## Configuration
- MULTICYCLE_CTRL_MISALIGN_TRAP_EN, when defined:
  - In EXECUTE, a LOAD/STORE whose rs1_data+immediate is misaligned enters TRAP instead of MEMORY.
    - Halfword (func3[1:0]=01) is misaligned if addr[0]≠0.
    - Word (func3[1:0]=10) is misaligned if addr[1:0]≠0.
  - A BRANCH/JAL with pc_next[1:0]≠0 enters TRAP instead of FETCH.
  - On trap: pc is not updated, instret is not incremented, reg_wen=0.
- When undefined: no alignment checks, the TRAP state is unreachable, and trap is tied to 0.

## Test plan
- Reset then zero-wait fetch of 0x00500093 (JAL class, pc_next=4) -> instruction=0x00500093, reg_wen pulses in EXECUTE, pc=4, instret=1 after 2 cycles.
- Fetch with mem_ready held low 3 cycles -> mem_req=1 and mem_addr=pc held stable for 4 cycles, instruction captured only on the mem_ready cycle.
- LOAD, rs1_data=0x100, immediate=0x8, func3=010, 2 wait states -> mem_addr=0x108, mem_wen=0, reg_wen only on the mem_ready cycle, total 1+1+3 cycles, instret+1.
- STORE, rs1_data=0xFFFFFFFC, immediate=8 -> mem_addr=0x00000004 (wrap), mem_wen=1, reg_wen never asserted.
- rst asserted in MEMORY while mem_ready=0 -> next cycle state FETCH, pc=RESET_PC, instret=0, mem_req=0 while rst is high.
- With MULTICYCLE_CTRL_MISALIGN_TRAP_EN: LOAD func3=010 to addr 0x102 -> trap=1 and stays 1, mem_req=0, pc and instret unchanged. Without the macro: access issued at 0x102.
